// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
// Groups the three request/ack channels, the clear pulse and the display
// outputs shared between the requesters and the arbiter.
//   master : requester side (drives valids/data/clear, sees acks and display)
//   slave  : arbiter side (sees valids/data/clear, drives acks and display)
interface seg_display_arbiter_if;
  logic        entry_valid;
  logic [15:0] entry_data;
  logic        entry_ack;
  logic        result_valid;
  logic [15:0] result_data;
  logic        result_ack;
  logic        err_valid;
  logic [3:0]  err_code;
  logic        err_ack;
  logic        clear;
  logic [15:0] displayed_number;
  logic        display_sel;
  logic [1:0]  active_src;

  modport master (
    output entry_valid, entry_data, result_valid, result_data,
           err_valid, err_code, clear,
    input  entry_ack, result_ack, err_ack,
           displayed_number, display_sel, active_src
  );

  modport slave (
    input  entry_valid, entry_data, result_valid, result_data,
           err_valid, err_code, clear,
    output entry_ack, result_ack, err_ack,
           displayed_number, display_sel, active_src
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares the 4-digit seven-segment display between keyboard entry echo,
// calculator result and error status. Priority: err > clear > result > entry.
// Results and errors are held on screen for HOLD_CYCLES before a
// lower-priority source may replace them; display_sel stays high for
// LATCH_CYCLES after each update so the driver latch captures it.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : slave side of seg_display_arbiter_if (requests, acks, display)
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned LATCH_CYCLES = 1_048_576,
  parameter int unsigned CNT_W        = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_RESULT = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        disp_q, disp_d;
  logic               sel_q, sel_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   latch_q, latch_d;

  logic hold_done;
  logic acc_err, acc_clr, acc_res, acc_ent, any_acc;

  always_comb begin
    hold_done = (hold_q == '0);
    acc_err   = bus.err_valid;
    acc_clr   = bus.clear & ~bus.err_valid;
    acc_res   = bus.result_valid & ~bus.err_valid & ~bus.clear &
                ((state_q != S_ERROR) | hold_done);
    // Entry yields only to an actual higher-priority acceptance, not to a
    // blocked higher-priority request.
    acc_ent   = bus.entry_valid & ~bus.err_valid & ~bus.clear & ~acc_res &
                ((state_q == S_IDLE) | (state_q == S_ENTRY) | hold_done);
    any_acc   = acc_err | acc_clr | acc_res | acc_ent;

    state_d = state_q;
    disp_d  = disp_q;
    hold_d  = hold_done ? '0 : hold_q - CNT_W'(1);
    latch_d = (latch_q == '0) ? '0 : latch_q - CNT_W'(1);
    // display_sel falls one edge after the latch counter has reached zero.
    sel_d   = (latch_q == '0) ? 1'b0 : sel_q;

    if (any_acc) begin
      latch_d = LATCH_LOAD;
      sel_d   = 1'b1;
    end

    if (acc_err) begin
      state_d = S_ERROR;
      disp_d  = {8'hEE, 4'h0, bus.err_code};
      hold_d  = HOLD_LOAD;
    end else if (acc_clr) begin
      state_d = S_IDLE;
      disp_d  = '0;
      hold_d  = '0;
    end else if (acc_res) begin
      state_d = S_RESULT;
      disp_d  = bus.result_data;
      hold_d  = HOLD_LOAD;
    end else if (acc_ent) begin
      state_d = S_ENTRY;
      disp_d  = bus.entry_data;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      disp_q  <= '0;
      sel_q   <= 1'b0;
      hold_q  <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      latch_q <= latch_d;
    end
  end

  // Acks are forced low while reset is asserted.
  assign bus.err_ack          = acc_err & reset;
  assign bus.result_ack       = acc_res & reset;
  assign bus.entry_ack        = acc_ent & reset;
  assign bus.displayed_number = disp_q;
  assign bus.display_sel      = sel_q;
  assign bus.active_src       = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;
  localparam int HOLD  = 8;
  localparam int LATCH = 4;
  localparam int CW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(
    .HOLD_CYCLES (HOLD),
    .LATCH_CYCLES(LATCH),
    .CNT_W       (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: what is shown, who owns it, when the last update
  // happened and from which cycle a lower-priority source may take over.
  int          m_src;
  logic [15:0] m_disp;
  int          m_last_upd;
  int          m_hold_rel;

  task automatic model_reset();
    m_src      = 0;
    m_disp     = 16'h0000;
    m_last_upd = -1000;
    m_hold_rel = 0;
  endtask

  // 0 none, 1 entry, 2 result, 3 err, 4 clear
  function automatic int model_kind();
    bit hold_ok;
    if (!reset) return 0;
    if (bus.err_valid) return 3;
    if (bus.clear) return 4;
    hold_ok = (cyc >= m_hold_rel);
    if (bus.result_valid && (m_src != 3 || hold_ok)) return 2;
    if (bus.entry_valid && (m_src <= 1 || hold_ok)) return 1;
    return 0;
  endfunction

  function automatic logic model_sel();
    return (cyc > m_last_upd) && (cyc <= m_last_upd + LATCH);
  endfunction

  task automatic tick();
    int k;
    logic [15:0] nd;
    k = model_kind();
    case (k)
      3:       nd = {8'hEE, 4'h0, bus.err_code};
      2:       nd = bus.result_data;
      1:       nd = bus.entry_data;
      default: nd = 16'h0000;
    endcase
    @(posedge clk);
    if (!reset) model_reset();
    else if (k != 0) begin
      m_disp     = nd;
      m_last_upd = cyc;
      m_src      = (k == 4) ? 0 : k;
      m_hold_rel = (k == 2 || k == 3) ? cyc + HOLD : cyc + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [2:0] acks();
    return {bus.err_ack, bus.result_ack, bus.entry_ack};
  endfunction

  task automatic test_reset();
    bus.entry_valid = 1'b1; bus.entry_data = 16'h1234;
    bus.result_valid = 1'b0; bus.result_data = 16'h0;
    bus.err_valid = 1'b0; bus.err_code = 4'h0; bus.clear = 1'b0;
    model_reset();
    #3;
    n_cmp++; if (bus.displayed_number !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h want 0000", bus.displayed_number); end
    n_cmp++; if (bus.display_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", bus.display_sel); end
    n_cmp++; if (bus.active_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus.active_src); end
    n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", acks()); end
    @(negedge clk);
    tick();
  endtask

  task automatic test_entry_after_reset();
    int cnt;
    reset = 1'b1;
    #1;
    n_cmp++; if (acks() !== 3'b001) begin n_fail++; $display("FAIL entry_first_ack: got %b want 001", acks()); end
    tick();
    bus.entry_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h1234) begin n_fail++; $display("FAIL entry_disp: got %h want 1234", bus.displayed_number); end
    n_cmp++; if (bus.active_src !== 2'd1) begin n_fail++; $display("FAIL entry_src: got %0d want 1", bus.active_src); end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.display_sel === 1'b1) cnt++;
      tick(); #1;
    end
    n_cmp++; if (cnt != LATCH) begin n_fail++; $display("FAIL entry_sel_len: got %0d want %0d", cnt, LATCH); end
  endtask

  task automatic test_result_hold();
    bus.result_valid = 1'b1; bus.result_data = 16'h0042;
    #1;
    n_cmp++; if (acks() !== 3'b010) begin n_fail++; $display("FAIL hold_result_ack: got %b want 010", acks()); end
    tick();
    bus.result_valid = 1'b0; bus.entry_valid = 1'b1; bus.entry_data = 16'h0005;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h0042 || bus.active_src !== 2'd2) begin n_fail++; $display("FAIL hold_result_disp: got %h/%0d want 0042/2", bus.displayed_number, bus.active_src); end
    n_cmp++; if (bus.entry_ack !== 1'b0) begin n_fail++; $display("FAIL hold_block_1: got %b want 0", bus.entry_ack); end
    for (int i = 2; i <= HOLD - 1; i++) begin
      tick(); #1;
      n_cmp++; if (bus.entry_ack !== 1'b0) begin n_fail++; $display("FAIL hold_block_%0d: got %b want 0", i, bus.entry_ack); end
    end
    tick(); #1;
    n_cmp++; if (bus.entry_ack !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", bus.entry_ack); end
    tick();
    bus.entry_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h0005 || bus.active_src !== 2'd1) begin n_fail++; $display("FAIL hold_entry_disp: got %h/%0d want 0005/1", bus.displayed_number, bus.active_src); end
  endtask

  task automatic test_priority();
    bus.clear = 1'b1; #1; tick(); bus.clear = 1'b0;
    bus.err_valid = 1'b1; bus.err_code = 4'h3;
    bus.result_valid = 1'b1; bus.result_data = 16'h0777;
    bus.entry_valid = 1'b1; bus.entry_data = 16'h0888;
    #1;
    n_cmp++; if (acks() !== 3'b100) begin n_fail++; $display("FAIL prio_err_only: got %b want 100", acks()); end
    tick();
    bus.err_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'hEE03 || bus.active_src !== 2'd3) begin n_fail++; $display("FAIL prio_err_disp: got %h/%0d want EE03/3", bus.displayed_number, bus.active_src); end
    n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL prio_wait_r1: got %b want 000", acks()); end
    for (int i = 2; i <= HOLD - 1; i++) begin
      tick(); #1;
      n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL prio_wait_r%0d: got %b want 000", i, acks()); end
    end
    tick(); #1;
    n_cmp++; if (acks() !== 3'b010) begin n_fail++; $display("FAIL prio_result_ack: got %b want 010", acks()); end
    tick();
    bus.result_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h0777 || bus.active_src !== 2'd2) begin n_fail++; $display("FAIL prio_result_disp: got %h/%0d want 0777/2", bus.displayed_number, bus.active_src); end
    for (int i = 1; i <= HOLD - 1; i++) begin
      if (i > 1) begin tick(); #1; end
      n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL prio_wait_e%0d: got %b want 000", i, acks()); end
    end
    tick(); #1;
    n_cmp++; if (acks() !== 3'b001) begin n_fail++; $display("FAIL prio_entry_ack: got %b want 001", acks()); end
    tick();
    bus.entry_valid = 1'b0;
  endtask

  task automatic test_err_preempt();
    bus.result_valid = 1'b1; bus.result_data = 16'h1111;
    #1;
    n_cmp++; if (acks() !== 3'b010) begin n_fail++; $display("FAIL preempt_result_ack: got %b want 010", acks()); end
    tick();
    bus.result_valid = 1'b0;
    #1; tick();
    bus.err_valid = 1'b1; bus.err_code = 4'hA;
    #1;
    n_cmp++; if (acks() !== 3'b100) begin n_fail++; $display("FAIL preempt_err_ack: got %b want 100", acks()); end
    tick();
    bus.err_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'hEE0A || bus.active_src !== 2'd3) begin n_fail++; $display("FAIL preempt_disp: got %h/%0d want EE0A/3", bus.displayed_number, bus.active_src); end
  endtask

  task automatic test_clear();
    int cnt;
    bus.clear = 1'b1;
    #1;
    n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL clear_no_ack: got %b want 000", acks()); end
    tick();
    bus.clear = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h0000 || bus.active_src !== 2'd0) begin n_fail++; $display("FAIL clear_disp: got %h/%0d want 0000/0", bus.displayed_number, bus.active_src); end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.display_sel === 1'b1) cnt++;
      tick(); #1;
    end
    n_cmp++; if (cnt != LATCH) begin n_fail++; $display("FAIL clear_sel_len: got %0d want %0d", cnt, LATCH); end
    bus.clear = 1'b1; bus.err_valid = 1'b1; bus.err_code = 4'h7;
    #1;
    n_cmp++; if (acks() !== 3'b100) begin n_fail++; $display("FAIL clear_vs_err_ack: got %b want 100", acks()); end
    tick();
    bus.clear = 1'b0; bus.err_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'hEE07 || bus.active_src !== 2'd3) begin n_fail++; $display("FAIL clear_vs_err_disp: got %h/%0d want EE07/3", bus.displayed_number, bus.active_src); end
  endtask

  task automatic test_async_reset();
    int  waited;
    bit  got;
    waited = 0; got = 0;
    bus.result_valid = 1'b1; bus.result_data = 16'h0BEE;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (bus.result_ack === 1'b1) got = 1;
      else begin tick(); waited++; end
    end
    n_cmp++; if (!got || waited != HOLD - 1) begin n_fail++; $display("FAIL err_hold_wait: got ack=%0d after %0d want ack=1 after %0d", got, waited, HOLD - 1); end
    tick();
    bus.result_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (bus.display_sel !== 1'b1 || bus.active_src !== 2'd2) begin n_fail++; $display("FAIL pre_reset_state: got sel=%b src=%0d want sel=1 src=2", bus.display_sel, bus.active_src); end
    #1;
    reset = 1'b0;
    bus.result_valid = 1'b1; bus.result_data = 16'h2222;
    #1;
    model_reset();
    n_cmp++; if (bus.displayed_number !== 16'h0000 || bus.display_sel !== 1'b0 || bus.active_src !== 2'd0) begin n_fail++; $display("FAIL async_reset_out: got %h/%b/%0d want 0000/0/0", bus.displayed_number, bus.display_sel, bus.active_src); end
    n_cmp++; if (acks() !== 3'b000) begin n_fail++; $display("FAIL async_reset_acks: got %b want 000", acks()); end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (acks() !== 3'b010) begin n_fail++; $display("FAIL post_reset_ack: got %b want 010", acks()); end
    tick();
    bus.result_valid = 1'b0;
    #1;
    n_cmp++; if (bus.displayed_number !== 16'h2222 || bus.active_src !== 2'd2 || bus.display_sel !== 1'b1) begin n_fail++; $display("FAIL post_reset_disp: got %h/%0d/%b want 2222/2/1", bus.displayed_number, bus.active_src, bus.display_sel); end
  endtask

  task automatic test_random();
    int k;
    logic [2:0] ea;
    for (int i = 0; i < 600; i++) begin
      if (!bus.err_valid && $urandom_range(99) < 3) begin
        bus.err_valid = 1'b1; bus.err_code = 4'($urandom);
      end
      if (!bus.result_valid && $urandom_range(99) < 8) begin
        bus.result_valid = 1'b1; bus.result_data = 16'($urandom);
      end
      if (!bus.entry_valid && $urandom_range(99) < 35) begin
        bus.entry_valid = 1'b1; bus.entry_data = 16'($urandom);
      end
      bus.clear = ($urandom_range(99) < 3);
      #1;
      k  = model_kind();
      ea = {k == 3, k == 2, k == 1};
      n_cmp++; if (acks() !== ea) begin n_fail++; $display("FAIL rand_acks c%0d: got %b want %b", cyc, acks(), ea); end
      n_cmp++; if (bus.displayed_number !== m_disp) begin n_fail++; $display("FAIL rand_disp c%0d: got %h want %h", cyc, bus.displayed_number, m_disp); end
      n_cmp++; if (bus.active_src !== 2'(m_src)) begin n_fail++; $display("FAIL rand_src c%0d: got %0d want %0d", cyc, bus.active_src, m_src); end
      n_cmp++; if (bus.display_sel !== model_sel()) begin n_fail++; $display("FAIL rand_sel c%0d: got %b want %b", cyc, bus.display_sel, model_sel()); end
      tick();
      if (k == 3) bus.err_valid = 1'b0;
      if (k == 2) bus.result_valid = 1'b0;
      if (k == 1) bus.entry_valid = 1'b0;
      bus.clear = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_entry_after_reset();
    test_result_hold();
    test_priority();
    test_err_preempt();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the 4-digit seven-segment display between three sources in the calculator: keyboard entry echo, calculator result, and error status. Sits between the PS/2 decode / calculator core and the seven-segment driver. Drives the driver's `displayed_number` and `display_sel` inputs. Enforces priority and a minimum on-screen hold time, and holds `display_sel` high long enough for the driver's refresh-period latch to capture each update.

## Interface
- `HOLD_CYCLES`, default 100_000_000: minimum cycles a result or error stays shown before a lower-priority source may replace it (1 s at 100 MHz).
- `LATCH_CYCLES`, default 1_048_576: cycles `display_sel` stays high after each update (one full driver refresh period).
- `CNT_W`, default 27: width of the hold and latch counters; must hold both `HOLD_CYCLES-1` and `LATCH_CYCLES-1`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `entry_valid`  in  1  keyboard entry value pending; held until ack.
- `entry_data`  in  16  4 hex digits of the entry.
- `entry_ack`  out  1  entry accepted this cycle (combinational).
- `result_valid`  in  1  calculator result pending; held until ack.
- `result_data`  in  16  result digits.
- `result_ack`  out  1  result accepted this cycle (combinational).
- `err_valid`  in  1  error pending; held until ack.
- `err_code`  in  4  error code.
- `err_ack`  out  1  error accepted this cycle (combinational).
- `clear`  in  1  single-cycle pulse that blanks the display to 0000.
- `displayed_number`  out  16  registered; goes to the display driver.
- `display_sel`  out  1  registered; goes to the display driver latch enable.
- `active_src`  out  2  registered; 0 = IDLE, 1 = ENTRY, 2 = RESULT, 3 = ERROR.

## Operation
State machine states are IDLE, ENTRY, RESULT and ERROR. `active_src` mirrors the state.

Acceptance in cycle T (evaluated from the registered state and counters, `hold_done` = hold counter == 0):
- **err_valid:** accepted in any state.
- **clear:** accepted in any state if no err_valid in the same cycle. Produces no ack.
- **result_valid:** accepted if no err or clear this cycle, and the state is not ERROR or `hold_done`.
- **entry_valid:** accepted if no higher-priority acceptance this cycle, and the state is IDLE or ENTRY, or `hold_done`.

At most one acceptance per cycle. A request that is not accepted gets no ack and stays pending. Requesters keep valid and data stable until their ack.

Update at the edge ending cycle T:
- **err:** state → ERROR; `displayed_number` = {4'hE, 4'hE, 4'h0, err_code}.
- **result:** state → RESULT; `displayed_number` = `result_data`.
- **entry:** state → ENTRY; `displayed_number` = `entry_data`.
- **clear:** state → IDLE; `displayed_number` = 0.

Counter behaviour on any acceptance, including clear:
- The latch counter loads `LATCH_CYCLES-1` and `display_sel` goes to 1.
- The hold counter loads `HOLD_CYCLES-1` for err and result, and 0 for entry and clear.

With no acceptance:
- Each counter decrements toward 0 and saturates at 0.
- `display_sel` drops to 0 on the edge after the latch counter reaches 0.

A new acceptance while `display_sel` is high reloads the latch counter, so `display_sel` stays high continuously.

An identical value re-accepted is treated as a new update: it is acked and both counters reload.

## Timing
- **Reset (`reset` = 0), asynchronous:**
  - state IDLE
  - `displayed_number` = 0x0000
  - `display_sel` = 0
  - `active_src` = 0
  - both counters 0
  - all acks 0 while reset is asserted
- Reset mid-hold or mid-latch aborts immediately; pending requests are re-evaluated from IDLE on the first cycle after release.
- Ack latency is 0 cycles (same cycle as valid when accepted). Output latency is 1 edge after the ack cycle.
- `display_sel` is high for exactly `LATCH_CYCLES` cycles after the last update.
- Hold: a lower-priority request presented continuously is acked in cycle T+`HOLD_CYCLES`, where T is the accepting cycle of the result or error.
- Entry in ENTRY state is accepted back-to-back every cycle, with no hold.
- Error while in ERROR: accepted immediately; the new code replaces the old one and the hold restarts.

## Test plan
Use `HOLD_CYCLES`=8 and `LATCH_CYCLES`=4 unless noted.
- Release reset with `entry_valid`=1 and `entry_data`=0x1234 → `entry_ack`=1 in that cycle. At the next edge `displayed_number`=0x1234 and `active_src`=1. `display_sel` is high for exactly 4 cycles.
- In ENTRY, accept `result_data`=0x0042, then hold `entry_valid` with data 0x0005 from the next cycle → no `entry_ack` for 7 cycles. `entry_ack` occurs in the 8th cycle after the result ack, then `displayed_number`=0x0005.
- Assert `err_valid` (code 3), `result_valid` and `entry_valid` together in IDLE → only `err_ack`; `displayed_number`=0xEE03. `result_ack` comes 8 cycles later. `entry_ack` comes 8 cycles after that.
- During a RESULT hold, assert `err_valid` with code 0xA → `err_ack` in the same cycle, and `displayed_number`=0xEE0A at the next edge.
- In ERROR, pulse `clear` → state IDLE, `displayed_number`=0x0000, `display_sel` high for 4 cycles. Then `clear` and `err_valid` in the same cycle → the err wins and the display shows the error.
- Assert `reset`=0 asynchronously mid-latch while in RESULT → all outputs 0 immediately, with no clock edge required. After release, a held `result_valid` is acked on the first cycle.
